sdm_modulator_256: RTL

SDM_MODULATOR_256 -- requirements
Module: sdm_modulator_256

---
 rtl/sdm_modulator_256.sv | 105 ++++++++++
 1 files changed

// File: rtl/sdm_modulator_256.sv
// Second-order 1-bit sigma-delta modulator with a 256x frame counter and a
// single-entry sample holding buffer that feeds the active sample once per frame.
module sdm_modulator_256 #(
  parameter int DATA_W = 22,
  parameter int ACC_W  = 26
) (
  input  logic                     clk_fs,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     data_valid,
  output logic                     data_ready,
  output logic                     pdm_out,
  output logic                     underrun
);

  localparam int SW = ACC_W + 2;
  localparam logic signed [DATA_W-1:0] X_MAX = DATA_W'(2**(DATA_W-3) - 1);
  localparam logic signed [DATA_W-1:0] X_MIN = DATA_W'(-(2**(DATA_W-3)));
  localparam logic signed [SW-1:0]     V_POS = SW'(2**(DATA_W-2));
  localparam logic signed [SW-1:0]     V_NEG = -V_POS;
  localparam logic signed [SW-1:0]     S_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0]     S_MIN = {3'b111, {(ACC_W-1){1'b0}}};

  logic        [7:0]        r_cnt;
  logic                     r_full;
  logic signed [DATA_W-1:0] r_buf;
  logic signed [DATA_W-1:0] r_x;
  logic signed [ACC_W-1:0]  r_i1;
  logic signed [ACC_W-1:0]  r_i2;
  logic                     r_underrun;

  logic                     w_boundary;
  logic                     w_accept;
  logic signed [DATA_W-1:0] w_load_raw;
  logic signed [DATA_W-1:0] w_load;
  logic signed [SW-1:0]     w_v;
  logic signed [SW-1:0]     w_s1;
  logic signed [SW-1:0]     w_s2;
  logic signed [ACC_W-1:0]  w_i1_next;
  logic signed [ACC_W-1:0]  w_i2_next;

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SW-1:0] s);
    if (s > S_MAX)
      return S_MAX[ACC_W-1:0];
    else if (s < S_MIN)
      return S_MIN[ACC_W-1:0];
    else
      return s[ACC_W-1:0];
  endfunction

  assign w_boundary = (r_cnt == 8'd255);
  assign w_accept   = data_valid && !r_full;
  assign data_ready = !r_full;
  assign pdm_out    = !r_i2[ACC_W-1];
  assign underrun   = r_underrun;

  // A buffered word has priority; otherwise a boundary handshake bypasses to x.
  always_comb begin
    w_load_raw = r_full ? r_buf : data_in;
    w_load     = w_load_raw;
    if (w_load_raw > X_MAX)
      w_load = X_MAX;
    else if (w_load_raw < X_MIN)
      w_load = X_MIN;
  end

  always_comb begin
    w_v       = pdm_out ? V_POS : V_NEG;
    w_s1      = {{2{r_i1[ACC_W-1]}}, r_i1} + {{(SW-DATA_W){r_x[DATA_W-1]}}, r_x} - w_v;
    w_i1_next = sat_acc(w_s1);
    w_s2      = {{2{r_i2[ACC_W-1]}}, r_i2} + {{2{w_i1_next[ACC_W-1]}}, w_i1_next} - w_v;
    w_i2_next = sat_acc(w_s2);
  end

  always_ff @(posedge clk_fs or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_full     <= 1'b0;
      r_buf      <= '0;
      r_x        <= '0;
      r_i1       <= '0;
      r_i2       <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_cnt      <= r_cnt + 8'd1;
      r_i1       <= w_i1_next;
      r_i2       <= w_i2_next;
      r_underrun <= 1'b0;
      if (w_boundary) begin
        if (r_full) begin
          r_x    <= w_load;
          r_full <= 1'b0;
        end else if (w_accept) begin
          r_x <= w_load;
        end else begin
          r_underrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_buf  <= data_in;
        r_full <= 1'b1;
      end
    end
  end

endmodule
